// File: rtl/handshake_monitor.sv
// Passive per-channel valid/ready protocol checker: counts transfers and latches
// sticky valid-drop, payload-change and stall-timeout errors plus the first failing channel.
module handshake_monitor #(
  parameter  int N_CHANNELS = 3,
  parameter  int DATA_WIDTH = 4,
  parameter  int TIMEOUT    = 16,
  parameter  int CNT_WIDTH  = 16,
  localparam int CHAN_W     = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                             CLK,
  input  logic                             ASYNCRESETN,
  input  logic                             enable,
  input  logic                             clear_errors,
  input  logic [N_CHANNELS-1:0]            valid,
  input  logic [N_CHANNELS-1:0]            ready,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] data,
  output logic [N_CHANNELS*CNT_WIDTH-1:0]  xfer_count,
  output logic [N_CHANNELS-1:0]            err_valid_drop,
  output logic [N_CHANNELS-1:0]            err_data_change,
  output logic [N_CHANNELS-1:0]            err_timeout,
  output logic                             err_any,
  output logic [CHAN_W-1:0]                first_err_chan,
  output logic [N_CHANNELS-1:0]            stalled
);

  localparam int SW = $clog2(TIMEOUT + 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  logic [N_CHANNELS-1:0] state_q, state_d;
  logic [DATA_WIDTH-1:0] held_q  [N_CHANNELS];
  logic [DATA_WIDTH-1:0] held_d  [N_CHANNELS];
  logic [SW-1:0]         stall_q [N_CHANNELS];
  logic [SW-1:0]         stall_d [N_CHANNELS];
  logic [CNT_WIDTH-1:0]  cnt_q   [N_CHANNELS];
  logic [CNT_WIDTH-1:0]  cnt_d   [N_CHANNELS];
  logic [N_CHANNELS-1:0] drop_q, drop_d;
  logic [N_CHANNELS-1:0] chg_q, chg_d;
  logic [N_CHANNELS-1:0] to_q, to_d;
  logic [CHAN_W-1:0]     first_q, first_d;

  logic [N_CHANNELS-1:0] new_drop, new_chg, new_to, new_err;
  logic [CHAN_W-1:0]     lowest;

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    stall_d  = stall_q;
    cnt_d    = cnt_q;
    new_drop = '0;
    new_chg  = '0;
    new_to   = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      if (enable && valid[i] && ready[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (!enable) begin
        state_d[i] = ST_IDLE;
        stall_d[i] = '0;
      end else if (state_q[i] == ST_IDLE) begin
        if (valid[i] && !ready[i]) begin
          state_d[i] = ST_WAIT;
          held_d[i]  = data[i*DATA_WIDTH +: DATA_WIDTH];
          stall_d[i] = SW'(1);
        end
      end else if (!valid[i]) begin
        new_drop[i] = 1'b1;
        state_d[i]  = ST_IDLE;
        stall_d[i]  = '0;
      end else begin
        if (data[i*DATA_WIDTH +: DATA_WIDTH] != held_q[i]) begin
          new_chg[i] = 1'b1;
        end
        if (ready[i]) begin
          state_d[i] = ST_IDLE;
          stall_d[i] = '0;
        end else if (stall_q[i] < SW'(TIMEOUT)) begin
          // Count saturates at TIMEOUT, so the timeout error fires exactly once per stall.
          stall_d[i] = stall_q[i] + 1'b1;
          if (stall_q[i] == SW'(TIMEOUT - 1)) begin
            new_to[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    new_err = new_drop | new_chg | new_to;
    lowest  = '0;
    for (int unsigned i = N_CHANNELS; i > 0; i--) begin
      if (new_err[i-1]) begin
        lowest = CHAN_W'(i - 1);
      end
    end
    first_d = first_q;
    if (clear_errors) begin
      // A new error in the clearing cycle survives and becomes the first error.
      drop_d  = new_drop;
      chg_d   = new_chg;
      to_d    = new_to;
      first_d = (|new_err) ? lowest : '0;
    end else begin
      drop_d = drop_q | new_drop;
      chg_d  = chg_q | new_chg;
      to_d   = to_q | new_to;
      if (!err_any && (|new_err)) begin
        first_d = lowest;
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= '0;
      drop_q  <= '0;
      chg_q   <= '0;
      to_q    <= '0;
      first_q <= '0;
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
        held_q[i]  <= '0;
        stall_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      stall_q <= stall_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      chg_q   <= chg_d;
      to_q    <= to_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      xfer_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      stalled[i] = (state_q[i] == ST_WAIT);
    end
  end

  assign err_valid_drop  = drop_q;
  assign err_data_change = chg_q;
  assign err_timeout     = to_q;
  assign err_any         = (|drop_q) | (|chg_q) | (|to_q);
  assign first_err_chan  = first_q;

endmodule

// File: doc/handshake_monitor.md
# handshake_monitor

Passive, parametrised protocol monitor for N independent valid/ready channels, each carrying a DATA_WIDTH payload. It sits beside any handshake boundary as a simulation-and-silicon checker, generalising single-cycle property checks into a sequential per-channel tracker. It counts completed transfers, flags valid-drop, payload-change and stall-timeout violations as sticky error bits, and records which channel failed first.

## Interface
- N_CHANNELS, 3, number of monitored channels (>=1)
- DATA_WIDTH, 4, payload width per channel (>=1)
- TIMEOUT, 16, max consecutive stalled cycles before timeout error (>=2)
- CNT_WIDTH, 16, width of each per-channel transfer counter
- CHAN_W, derived, $clog2(N_CHANNELS) (minimum 1)

- CLK  in  1  clock, rising edge
- ASYNCRESETN  in  1  asynchronous, active-low reset
- enable  in  1  monitoring enable; low = trackers idle, counters hold
- clear_errors  in  1  synchronous clear of all sticky error state
- valid  in  N_CHANNELS  per-channel valid
- ready  in  N_CHANNELS  per-channel ready
- data  in  N_CHANNELS*DATA_WIDTH  payloads, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- xfer_count  out  N_CHANNELS*CNT_WIDTH  saturating transfer counts, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
- err_valid_drop  out  N_CHANNELS  sticky: valid fell before ready
- err_data_change  out  N_CHANNELS  sticky: payload changed while stalled
- err_timeout  out  N_CHANNELS  sticky: stall reached TIMEOUT cycles
- err_any  out  1  OR of all error bits
- first_err_chan  out  CHAN_W  index of first channel to flag an error
- stalled  out  N_CHANNELS  channel currently in WAIT

## Operation
- Per-channel FSM, states IDLE and WAIT; transfer = valid & ready in a cycle with enable high.
- IDLE: valid & !ready -> WAIT, capture data into held_data, stall_cnt <= 1. Otherwise stay.
- WAIT, each cycle:
  - !valid -> set err_valid_drop[i], go IDLE.
  - valid & data != held_data -> set err_data_change[i]; stay in WAIT unless ready.
  - valid & ready -> transfer, go IDLE, stall_cnt <= 0.
  - valid & !ready -> stall_cnt increments, saturating at TIMEOUT; when it reaches TIMEOUT set err_timeout[i] (once; remains WAIT).
- Payload compare and transfer in the same cycle: both data-change error and transfer recorded.
- xfer_count[i] increments on each transfer, saturates at all-ones (no wrap).
- Error bits sticky until clear_errors or reset. first_err_chan latched when err_any goes 0->1; simultaneous first errors -> lowest channel index wins. Cleared to 0 by clear_errors.
- clear_errors and a new error in the same cycle: new error sets (set dominates clear); first_err_chan takes the new error's channel.
- enable low: all FSMs forced IDLE, stall_cnt 0, no new errors, counters hold, sticky errors hold.
- err_any and stalled combinational from registered state.

## Timing
- Reset (ASYNCRESETN low, asynchronous): all FSMs IDLE, xfer_count 0, all error bits 0, first_err_chan 0, stalled 0. Reset mid-stall discards the stall with no error.
- Errors and counts are registered: visible the cycle after the violating/transfer edge.
- Timeout: valid rises with ready low at edge 0; err_timeout visible after edge TIMEOUT-1, i.e. TIMEOUT stalled cycles observed.
- stalled[i] high from the cycle after entering WAIT until the cycle after leaving it.
- No outputs drive the monitored interface; zero added latency to DUT.

## Test plan
- Ch0: valid=1,data=4'h5,ready=0 for 3 cycles then ready=1 -> xfer_count[0]=1 one cycle later, no errors, stalled[0] high 3 cycles.
- Ch1: valid=1,ready=0, next cycle valid=0 -> err_valid_drop[1]=1, err_any=1, first_err_chan=1.
- Ch2: valid=1,data=4'hA,ready=0, next cycle data=4'hB -> err_data_change[2]=1; then clear_errors=1 -> all errors 0.
- Ch0 stall with TIMEOUT=16: valid=1,ready=0 held 16 cycles -> err_timeout[0] rises after 16th stalled edge, not earlier.
- Ch0 and ch2 violate in same cycle -> first_err_chan=0; assert clear_errors with simultaneous ch2 violation -> err_*[2]=1, first_err_chan=2.
- CNT_WIDTH=4, 20 back-to-back transfers on ch1 -> xfer_count[1]=4'hF; drop ASYNCRESETN mid-stall -> all outputs 0 immediately.
